// File: rtl/transpose_pkg.sv
// transpose_pkg: shared row type, skid FSM states and default transpose geometry
package transpose_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_NUM_PE = 8;
  typedef logic [DEF_DATA_WIDTH-1:0] row_t [0:DEF_NUM_PE-1];
  typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;
endpackage

// File: rtl/row_rotator.sv
// row_rotator: combinational row rotation, rot_row[j] = row[(j + shift) mod NUM_PE]
module row_rotator import transpose_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PE = DEF_NUM_PE,
  localparam int IDX_WIDTH = $clog2(NUM_PE)
) (
  input  logic [DATA_WIDTH-1:0] row [0:NUM_PE-1],
  input  logic [IDX_WIDTH-1:0]  shift,
  output logic [DATA_WIDTH-1:0] rot_row [0:NUM_PE-1]
);
  for (genvar j = 0; j < NUM_PE; j++) begin : g_rot
    assign rot_row[j] = row[IDX_WIDTH'(j) + shift];
  end
endmodule

// File: rtl/transpose_output_deskew.sv
// transpose_output_deskew: deskews transposed rows into a 2-entry skid buffer (optional stats via TRANSPOSE_DESKEW_STATS_EN)
module transpose_output_deskew import transpose_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PE = DEF_NUM_PE,
  localparam int IDX_WIDTH = $clog2(NUM_PE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_row [0:NUM_PE-1],
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_row [0:NUM_PE-1],
  output logic                  out_first,
`ifdef TRANSPOSE_DESKEW_STATS_EN
  output logic                  out_last,
  output logic [31:0]           blk_cnt,
  output logic [31:0]           stall_cnt
`else
  output logic                  out_last
`endif
);
  skid_state_t state, next_state;
  logic [IDX_WIDTH-1:0] row_idx;
  logic [DATA_WIDTH-1:0] rot_row [0:NUM_PE-1];
  logic [DATA_WIDTH-1:0] tail_row [0:NUM_PE-1];
  logic tail_first, tail_last, push, pop, is_first, is_last;
  assign push = in_val && in_rdy;
  assign pop = out_val && out_rdy;
  assign is_first = row_idx == '0;
  assign is_last = row_idx == IDX_WIDTH'(NUM_PE - 1);
  row_rotator #(.DATA_WIDTH(DATA_WIDTH), .NUM_PE(NUM_PE)) u_rot (
    .row(in_row),
    .shift(row_idx),
    .rot_row(rot_row)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      in_rdy <= 1'b1;
    end else begin
      state <= next_state;
      in_rdy <= next_state != FULL;
    end
  end
  always_comb begin
    next_state = state == EMPTY ? (push ? ONE : EMPTY) :
                 state == ONE   ? (push && !pop ? FULL : pop && !push ? EMPTY : ONE) :
                                  (pop ? ONE : FULL);
  end
  always_comb begin
    out_val = state != EMPTY;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_idx <= '0;
      out_row <= '{default: '0};
      out_first <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (push) row_idx <= row_idx + 1'b1;
      if (push && (state == EMPTY || (state == ONE && pop))) begin
        out_row <= rot_row;
        out_first <= is_first;
        out_last <= is_last;
      end else if (pop && state == FULL) begin
        out_row <= tail_row;
        out_first <= tail_first;
        out_last <= tail_last;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && state == ONE && !pop) begin
      tail_row <= rot_row;
      tail_first <= is_first;
      tail_last <= is_last;
    end
  end
`ifdef TRANSPOSE_DESKEW_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && out_last) blk_cnt <= blk_cnt + 1'b1;
      if (out_val && !out_rdy) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_transpose_output_deskew.sv
// tb_transpose_output_deskew: directed and random checks of row deskew, skid buffering and reset
module tb_transpose_output_deskew;
  import transpose_pkg::*;
  typedef struct {int seq; bit first; bit last;} exp_t;
  logic clk = 0, rst = 0, in_val = 0, out_rdy = 0;
  logic in_rdy, out_val, out_first, out_last;
  row_t in_row, out_row;
`ifdef TRANSPOSE_DESKEW_STATS_EN
  logic [31:0] blk_cnt, stall_cnt;
  logic [31:0] s0;
`endif
  exp_t q[$];
  int seq = 0, r = 0, total = 0, bad = 0, pops = 0, pops0 = 0, blk_exp = 0, stall_exp = 0, target = 0;
  always #5 clk = ~clk;
  transpose_output_deskew dut (
    .clk(clk),
    .rst(rst),
    .in_val(in_val),
    .in_rdy(in_rdy),
    .in_row(in_row),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_row(out_row),
    .out_first(out_first),
`ifdef TRANSPOSE_DESKEW_STATS_EN
    .out_last(out_last),
    .blk_cnt(blk_cnt),
    .stall_cnt(stall_cnt)
`else
    .out_last(out_last)
`endif
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic set_in(bit v);
    in_val = v;
    for (int k = 0; k < 8; k++)
      in_row[k] = (v && q.size() < 2) ? 64'(8 * seq + ((k - r) & 7)) : {$urandom, $urandom};
  endtask
  task automatic cycle();
    exp_t e;
    bit mpush, mpop;
    chk("out_val", out_val, q.size() != 0);
    chk("in_rdy", in_rdy, q.size() < 2);
    if (q.size() != 0) begin
      e = q[0];
      chk("out_first", out_first, e.first);
      chk("out_last", out_last, e.last);
      for (int j = 0; j < 8; j++) chk("out_row", out_row[j], 64'(8 * e.seq + j));
    end
    mpush = in_val && q.size() < 2;
    mpop = out_rdy && q.size() != 0;
    if (q.size() != 0 && !out_rdy) stall_exp++;
    if (mpop) begin
      pops++;
      if (q[0].last) blk_exp++;
      void'(q.pop_front());
    end
    if (mpush) begin
      q.push_back(exp_t'{seq, r == 0, r == 7});
      seq++;
      r = (r + 1) % 8;
    end
    @(posedge clk);
    #1;
`ifdef TRANSPOSE_DESKEW_STATS_EN
    chk("blk_cnt", blk_cnt, 64'(blk_exp));
    chk("stall_cnt", stall_cnt, 64'(stall_exp));
`endif
  endtask
  task automatic do_reset();
    rst = 0;
    set_in(1);
    @(posedge clk);
    #1;
    rst = 1;
    in_val = 0;
    q.delete();
    r = 0;
    blk_exp = 0;
    stall_exp = 0;
    chk("rst_out_val", out_val, 0);
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    for (int j = 0; j < 8; j++) chk("rst_row", out_row[j], 0);
`ifdef TRANSPOSE_DESKEW_STATS_EN
    chk("rst_blk", blk_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
`endif
  endtask
  initial begin
    for (int k = 0; k < 8; k++) in_row[k] = '0;
    do_reset();
    out_rdy = 1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(1);
      cycle();
    end
    set_in(0);
    cycle();
    chk("blk1_pops", pops, 8);
`ifdef TRANSPOSE_DESKEW_STATS_EN
    s0 = stall_cnt;
`endif
    out_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      set_in(1);
      cycle();
    end
    chk("stall_rdy", in_rdy, 0);
`ifdef TRANSPOSE_DESKEW_STATS_EN
    chk("stall5", stall_cnt - s0, 4);
`endif
    out_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(0);
      cycle();
    end
    out_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1);
      cycle();
    end
    chk("full_rdy", in_rdy, 0);
    do_reset();
    out_rdy = 1;
    pops0 = pops;
    set_in(1);
    cycle();
    chk("post_rst_first", out_first, 1);
    for (int i = 1; i < 24; i++) begin
      set_in(1);
      cycle();
    end
    set_in(0);
    cycle();
    chk("b2b_pops", pops - pops0, 24);
`ifdef TRANSPOSE_DESKEW_STATS_EN
    chk("b2b_blk", blk_cnt, 3);
`endif
    target = seq + 1000;
    for (int g = 0; g < 20000 && seq < target; g++) begin
      set_in(1'($urandom_range(0, 1)));
      out_rdy = 1'($urandom_range(0, 1));
      cycle();
    end
    out_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      set_in(0);
      cycle();
    end
    chk("drain_out_val", out_val, 0);
    chk("drain_in_rdy", in_rdy, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
